// File: rtl/axi_noc_traffic_checker.sv
// AXI4 master traffic checker: streams patterned INCR bursts to a NoC port and
// optionally reads them back, counting response and data-pattern errors.
module axi_noc_traffic_checker #(
    parameter int          DATA_W    = 512,
    parameter int          BURST_LEN = 4,
    parameter int          N_BURSTS  = 8,
    parameter int          MAX_OUTST = 2,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          ERR_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ERR_W-1:0]    err_cnt,
    output logic                awvalid,
    input  logic                awready,
    output logic [63:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [63:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rlast,
    input  logic [1:0]          rresp,
    output logic [1:0]          dbg_state
);

    localparam int          CW          = 17;
    localparam int          LANES       = DATA_W / 32;
    localparam logic [63:0] BURST_BYTES = 64'(BURST_LEN * (DATA_W / 8));
    localparam logic [CW-1:0] N_C       = CW'(N_BURSTS);
    localparam logic [CW-1:0] LAST_BURST = CW'(N_BURSTS - 1);
    localparam logic [CW-1:0] MAX_C     = CW'(MAX_OUTST);
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    function automatic logic [63:0] burst_addr(input logic [CW-1:0] k);
        return BASE_ADDR + 64'(k) * BURST_BYTES;
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [15:0] k, input logic [7:0] i);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int j = 0; j < LANES; j++) d[j*32 +: 32] = {k, i, 8'(j)};
        return d;
    endfunction

    state_t              r_state, w_state_n;
    logic [1:0]          r_mode;
    logic                r_err;
    logic [ERR_W-1:0]    r_err_cnt;
    logic                r_awvalid, r_wvalid, r_wlast, r_arvalid;
    logic [63:0]         r_awaddr, r_araddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CW-1:0]       r_aw_cnt, r_b_cnt, r_w_burst, r_ar_cnt, r_r_done;
    logic [7:0]          r_w_beat, r_r_beat;

    logic                w_start_ok, w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire;
    logic                w_w_last_fire, w_r_last_fire, w_r_bad, w_err_evt;
    logic [CW-1:0]       w_aw_cnt_n, w_b_cnt_n, w_w_burst_n, w_ar_cnt_n, w_r_done_n;
    logic [7:0]          w_w_beat_n, w_r_beat_n;

    assign w_start_ok    = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_aw_fire     = r_awvalid && awready;
    assign w_w_fire      = r_wvalid && wready;
    assign w_b_fire      = bvalid && bready;
    assign w_ar_fire     = r_arvalid && arready;
    assign w_r_fire      = rvalid && rready;
    assign w_w_last_fire = w_w_fire && (r_w_beat == LAST_BEAT);
    assign w_r_last_fire = w_r_fire && (r_r_beat == LAST_BEAT);

    // Next-cycle counter values let a new burst/beat be presented the cycle after a handshake.
    assign w_aw_cnt_n  = r_aw_cnt + CW'(w_aw_fire);
    assign w_b_cnt_n   = r_b_cnt + CW'(w_b_fire);
    assign w_w_burst_n = r_w_burst + CW'(w_w_last_fire);
    assign w_w_beat_n  = w_w_last_fire ? 8'd0 : (r_w_beat + 8'(w_w_fire));
    assign w_ar_cnt_n  = r_ar_cnt + CW'(w_ar_fire);
    assign w_r_done_n  = r_r_done + CW'(w_r_last_fire);
    assign w_r_beat_n  = w_r_last_fire ? 8'd0 : (r_r_beat + 8'(w_r_fire));

    assign w_r_bad   = (rdata != pattern(r_r_done[15:0], r_r_beat)) || (rresp != 2'b00) ||
                       (rlast != (r_r_beat == LAST_BEAT));
    assign w_err_evt = (w_b_fire && bresp != 2'b00) || (w_r_fire && w_r_bad);

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_n = (mode == 2'd1) ? S_READ : S_WRITE;
            S_WRITE:        if (r_b_cnt == N_C) w_state_n = (r_mode == 2'd0) ? S_DONE : S_READ;
            S_READ:         if (w_r_last_fire && r_r_done == LAST_BURST) w_state_n = S_DONE;
            default:        w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= 2'd0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_arvalid <= 1'b0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
            r_aw_cnt  <= '0;
            r_b_cnt   <= '0;
            r_w_burst <= '0;
            r_w_beat  <= '0;
            r_ar_cnt  <= '0;
            r_r_done  <= '0;
            r_r_beat  <= '0;
        end else if (w_start_ok) begin
            r_mode    <= mode;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_awvalid <= (mode != 2'd1);
            r_awaddr  <= BASE_ADDR;
            r_arvalid <= (mode == 2'd1);
            r_araddr  <= BASE_ADDR;
            r_wvalid  <= 1'b0;
            r_aw_cnt  <= '0;
            r_b_cnt   <= '0;
            r_w_burst <= '0;
            r_w_beat  <= '0;
            r_ar_cnt  <= '0;
            r_r_done  <= '0;
            r_r_beat  <= '0;
        end else begin
            if (r_state == S_WRITE) begin
                r_aw_cnt  <= w_aw_cnt_n;
                r_b_cnt   <= w_b_cnt_n;
                r_w_burst <= w_w_burst_n;
                r_w_beat  <= w_w_beat_n;
                if (!r_awvalid || w_aw_fire) begin
                    r_awvalid <= (w_aw_cnt_n < N_C) && ((w_aw_cnt_n - w_b_cnt_n) < MAX_C);
                    r_awaddr  <= burst_addr(w_aw_cnt_n);
                end
                if (!r_wvalid || w_w_fire) begin
                    r_wvalid <= (w_w_burst_n < w_aw_cnt_n);
                    r_wdata  <= pattern(w_w_burst_n[15:0], w_w_beat_n);
                    r_wlast  <= (w_w_beat_n == LAST_BEAT);
                end
                if (w_state_n == S_READ) begin
                    r_arvalid <= 1'b1;
                    r_araddr  <= BASE_ADDR;
                end
            end
            if (r_state == S_READ) begin
                r_ar_cnt <= w_ar_cnt_n;
                r_r_done <= w_r_done_n;
                r_r_beat <= w_r_beat_n;
                if (!r_arvalid || w_ar_fire) begin
                    r_arvalid <= (w_ar_cnt_n < N_C) && ((w_ar_cnt_n - w_r_done_n) < MAX_C);
                    r_araddr  <= burst_addr(w_ar_cnt_n);
                end
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
                if (r_err_cnt != {ERR_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign busy      = (r_state == S_WRITE) || (r_state == S_READ);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign awvalid   = r_awvalid;
    assign awaddr    = r_awaddr;
    assign awlen     = LAST_BEAT;
    assign awsize    = 3'($clog2(DATA_W / 8));
    assign awburst   = 2'b01;
    assign wvalid    = r_wvalid;
    assign wdata     = r_wdata;
    assign wstrb     = '1;
    assign wlast     = r_wlast;
    assign bready    = (r_state == S_WRITE);
    assign arvalid   = r_arvalid;
    assign araddr    = r_araddr;
    assign arlen     = LAST_BEAT;
    assign arsize    = 3'($clog2(DATA_W / 8));
    assign arburst   = 2'b01;
    assign rready    = (r_state == S_READ);
    assign dbg_state = r_state;

endmodule

// File: doc/axi_noc_traffic_checker.md
Name: axi_noc_traffic_checker

Overview:
- Parametrised successor to the single-pattern NoC transaction tester.
- Acts as an AXI4 master on a NoC port and issues a configurable number of INCR bursts with configurable burst length.
- Allows several write bursts and several read bursts in flight at once.
- Runs write-only, read-only, or write-then-read-verify; read data is checked against a deterministic pattern and errors are counted.
- Sits between the NoC NMU and the board-level wrapper, which ties off unlisted AXI sideband signals (cache, prot, qos, id, user).

Parameters:
DATA_W, 512, AXI data width; power of two, 64..1024
BURST_LEN, 4, beats per burst, 1..256; axlen = BURST_LEN-1
N_BURSTS, 8, bursts per phase, 1..65535
MAX_OUTST, 2, maximum write bursts awaiting B, and maximum read bursts awaiting last R, 1..16
BASE_ADDR, 64'h0, first burst address; must be aligned to BURST_LEN*DATA_W/8
ERR_W, 16, width of err_cnt

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins a run
mode  in  2  0 write-only, 1 read-only, 2/3 write-then-read-verify; sampled on accepted start
busy  out  1  run in progress
done  out  1  run complete; held until next accepted start
err  out  1  sticky: at least one error this run
err_cnt  out  ERR_W  error events this run, saturating
awvalid/awready  out/in  1  AW handshake
awaddr  out  64  burst address
awlen  out  8  BURST_LEN-1
awsize  out  3  log2(DATA_W/8)
awburst  out  2  2'b01
wvalid/wready  out/in  1  W handshake
wdata  out  DATA_W  pattern data
wstrb  out  DATA_W/8  all ones
wlast  out  1  last beat of burst
bvalid/bready  in/out  1  B handshake
bresp  in  2  write response
arvalid/arready  out/in  1  AR handshake
araddr  out  64  burst address
arlen  out  8  BURST_LEN-1
arsize  out  3  log2(DATA_W/8)
arburst  out  2  2'b01
rvalid/rready  in/out  1  R handshake
rdata  in  DATA_W  read data
rlast  in  1  last beat
rresp  in  2  read response

Behaviour:
- Reset: all valids, busy, done, err and err_cnt go to 0 immediately, and all counters clear. Reset asserted mid-run abandons the run; outstanding AXI responses are the environment's concern.
- Constant outputs: axlen, axsize, axburst and wstrb are constant regardless of reset.
- FSM: IDLE, WRITE, READ, DONE.
  - start in IDLE or DONE: latch mode, clear err/err_cnt/done, set busy. Go to WRITE for mode 0/2/3, READ for mode 1. awvalid/arvalid rise the cycle after start.
  - start in WRITE or READ: ignored.
  - WRITE to READ (mode 2/3), or WRITE to DONE (mode 0): when b_cnt == N_BURSTS.
  - READ to DONE: when the last beat of burst N_BURSTS-1 is accepted.
  - Entering DONE: done=1, busy=0.
- Address of burst k: BASE_ADDR + k*BURST_LEN*DATA_W/8, 64-bit wrap.
- AW issue: burst k is issued when aw_cnt < N_BURSTS and aw_cnt - b_cnt < MAX_OUTST. awvalid holds with stable addr until awready.
- W issue: the burst whose index equals w_burst streams only while w_burst < aw_cnt. W may follow AW by zero cycles (beat 0 valid in the cycle after AW is accepted). wvalid and wdata hold until wready. wlast is asserted on beat BURST_LEN-1.
- bready is tied to 1 in WRITE. Each B increments b_cnt. bresp != 0 counts as an error.
- AR issue: burst k is issued when ar_cnt < N_BURSTS and ar_cnt - r_done_cnt < MAX_OUTST.
- rready is tied to 1 in READ. Bursts are checked in order (single ID).
- Pattern: 32-bit lane j of beat i of burst k = {k[15:0], i[7:0], j[7:0]}.
- Read checks, each beat: one error per beat if any of the following hold:
  - rdata != pattern
  - rresp != 0
  - rlast != (i == BURST_LEN-1)
- Error counting: at most one B error per cycle and one R-beat error per cycle. A B error and an R error in the same cycle are not possible, because the phases are exclusive. err_cnt saturates at all ones; err is set on the first error.
- Simultaneous events: AW accept and B in the same cycle leave the outstanding count unchanged.
- Handshake signals (valid, ready, last) are never combinationally dependent on inputs. Other outputs (addr, data) come from registers.

Test Plan:
1. Defaults, mode 2, slave always ready with ideal memory -> 8 AW, 32 W beats, 8 AR, 32 R beats; done=1, err_cnt=0. wdata beat 1 of burst 2, lane 3 = 32'h00020103. awaddr of burst 1 = 0x100.
2. Defaults, mode 0, B delayed 20 cycles -> at most 2 AW accepted without B; awvalid held while 2 outstanding; done after 8th B.
3. Mode 2, slave corrupts one lane of R beat 5 and returns rresp=2 on beat 9 -> err=1, err_cnt=2; the run still completes with done=1.
4. Random wready/arready/rvalid backpressure at 50% with ideal memory -> every valid holds stable until handshake; err_cnt=0.
5. Assert rst during WRITE after 3 beats -> next cycle all valids 0, busy 0; start then rerun mode 2 -> clean completion, err_cnt=0.
6. BURST_LEN=1, N_BURSTS=1, MAX_OUTST=1 -> wlast asserted on every beat; done within 10 cycles with zero-latency slave.
